run_ctrl: RTL and testbench

Execution controller that sits directly upstream of the processor top. It produces the processor's per-cycle enable and its 32-bit executed-cycle `count`, and watches the processor's `op` output to stop on a halt opcode. It implements run, single-step and halt modes selected by the board switches and a debounced step push-button.

---
 rtl/run_ctrl.sv | 111 +++++++++++
 tb/tb_run_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Execution controller: run / single-step / halt sequencing for the processor,
// with a synchronized, debounced step button and a 32-bit executed-cycle count.
//
//  state | meaning
//  ------+--------------------------------------------------
//  IDLE  | processor stopped, waiting for run switch or step
//  RUN   | processor enabled every cycle while sw[0] is held
//  STEP  | processor enabled for exactly one cycle
//  HALT  | halt opcode executed; waits for sw[7] with sw[0]=0
module run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [5:0]  HALT_OP         = 6'h3F
) (
  input  logic        sysclk,
  input  logic        rstd,
  input  logic [7:0]  sw,
  input  logic        btn_step,
  input  logic [5:0]  op,
  output logic        cpu_en,
  output logic [31:0] count,
  output logic        halted,
  output logic [1:0]  state
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      btn_sync;
  logic            btn_deb;
  logic [DB_W-1:0] db_cnt;
  logic            step_req;
  logic [31:0]     count_q;
  logic            run_sw, clr_cnt_sw, clr_halt_sw;
  logic            op_halt;
  logic            unused_sw;

  assign run_sw      = sw[0];
  assign clr_cnt_sw  = sw[6];
  assign clr_halt_sw = sw[7];
  assign unused_sw   = ^sw[5:1];
  assign op_halt     = (op == HALT_OP);

  // step_req fires on the same edge the debounced level rises
  always_ff @(posedge sysclk) begin
    if (rstd) begin
      btn_sync <= 2'b00;
      btn_deb  <= 1'b0;
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], btn_step};
      step_req <= 1'b0;
      if (btn_sync[1] == btn_deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        btn_deb  <= btn_sync[1];
        step_req <= btn_sync[1];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rstd) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run_sw)        state_d = RUN;
        else if (step_req) state_d = STEP;
      end
      RUN: begin
        if (op_halt)      state_d = HALT;
        else if (!run_sw) state_d = IDLE;
      end
      STEP: state_d = op_halt ? HALT : IDLE;
      HALT: begin
        if (clr_halt_sw && !run_sw) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_en = (state_q == RUN) || (state_q == STEP);
    halted = (state_q == HALT);
  end

  always_ff @(posedge sysclk) begin
    if (rstd)                                 count_q <= '0;
    else if (cpu_en)                          count_q <= count_q + 32'd1;
    else if (state_q == IDLE && clr_cnt_sw)   count_q <= '0;
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: vector table through a scoreboard queue,
// plus hand sequences for button timing, bounce, run/stop, halt and wrap.
module tb_run_ctrl;

  logic        sysclk = 1'b0;
  logic        rstd;
  logic [7:0]  sw;
  logic        btn_step;
  logic [5:0]  op;
  logic        cpu_en;
  logic [31:0] count;
  logic        halted;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  run_ctrl #(.DEBOUNCE_CYCLES(16), .HALT_OP(6'h3F)) dut (
    .sysclk(sysclk), .rstd(rstd), .sw(sw), .btn_step(btn_step), .op(op),
    .cpu_en(cpu_en), .count(count), .halted(halted), .state(state)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [7:0]  sw;
    logic [5:0]  op;
    logic [1:0]  state;
    logic        cpu_en;
    logic        halted;
    logic [31:0] count;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  state;
    logic        cpu_en;
    logic        halted;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_outputs(input exp_t e);
    check({e.name, ".state"},  32'(state),  32'(e.state));
    check({e.name, ".cpu_en"}, 32'(cpu_en), 32'(e.cpu_en));
    check({e.name, ".halted"}, 32'(halted), 32'(e.halted));
    check({e.name, ".count"},  count,       e.count);
  endtask

  // Holds the button level for n cycles; returns enabled-pulse count and
  // the first cycle index (after the first sampling edge) with cpu_en=1.
  task automatic hold_btn(input logic lvl, input int n, output int pulses, output int first_idx);
    pulses = 0;
    first_idx = -1;
    btn_step = lvl;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cpu_en) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
  endtask

  vec_t vecs[17];
  int   pulses, first_idx, tot;

  initial begin
    vecs[0]  = '{8'h00, 6'h3F, 2'd0, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{8'h01, 6'h3F, 2'd1, 1'b1, 1'b0, 32'd0};
    vecs[2]  = '{8'h01, 6'h00, 2'd1, 1'b1, 1'b0, 32'd1};
    vecs[3]  = '{8'h00, 6'h00, 2'd0, 1'b0, 1'b0, 32'd2};
    vecs[4]  = '{8'h40, 6'h00, 2'd0, 1'b0, 1'b0, 32'd0};
    vecs[5]  = '{8'h41, 6'h00, 2'd1, 1'b1, 1'b0, 32'd0};
    vecs[6]  = '{8'h40, 6'h00, 2'd0, 1'b0, 1'b0, 32'd1};
    vecs[7]  = '{8'h01, 6'h00, 2'd1, 1'b1, 1'b0, 32'd1};
    vecs[8]  = '{8'h01, 6'h3F, 2'd3, 1'b0, 1'b1, 32'd2};
    vecs[9]  = '{8'h81, 6'h00, 2'd3, 1'b0, 1'b1, 32'd2};
    vecs[10] = '{8'h40, 6'h00, 2'd3, 1'b0, 1'b1, 32'd2};
    vecs[11] = '{8'h80, 6'h00, 2'd0, 1'b0, 1'b0, 32'd2};
    vecs[12] = '{8'h00, 6'h00, 2'd0, 1'b0, 1'b0, 32'd2};
    vecs[13] = '{8'h01, 6'h00, 2'd1, 1'b1, 1'b0, 32'd2};
    vecs[14] = '{8'h00, 6'h3F, 2'd3, 1'b0, 1'b1, 32'd3};
    vecs[15] = '{8'h80, 6'h00, 2'd0, 1'b0, 1'b0, 32'd3};
    vecs[16] = '{8'h40, 6'h00, 2'd0, 1'b0, 1'b0, 32'd0};

    // reset held with everything asserted
    rstd = 1'b1; sw = 8'hFF; btn_step = 1'b1; op = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outputs('{$sformatf("reset%0d", i), 2'd0, 1'b0, 1'b0, 32'd0});
    end
    rstd = 1'b0; sw = 8'h00; btn_step = 1'b0; op = 6'h00;
    tick();

    // vector table through the scoreboard
    for (int i = 0; i < 17; i++) begin
      sw = vecs[i].sw;
      op = vecs[i].op;
      sb.push_back('{$sformatf("vec%0d", i), vecs[i].state, vecs[i].cpu_en,
                     vecs[i].halted, vecs[i].count});
      tick();
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: queue empty at vec%0d", i);
      end else begin
        check_outputs(sb.pop_front());
      end
    end
    sw = 8'h00; op = 6'h00;
    check("sb_drained", 32'(sb.size()), 32'd0);

    // single step: one pulse, 18 cycles after the press is sampled
    hold_btn(1'b1, 40, pulses, first_idx);
    check("step1.pulses", 32'(pulses), 32'd1);
    check("step1.latency", 32'(first_idx), 32'd18);
    check("step1.count", count, 32'd1);
    hold_btn(1'b0, 40, pulses, first_idx);
    check("release1.pulses", 32'(pulses), 32'd0);
    hold_btn(1'b1, 40, pulses, first_idx);
    check("step2.pulses", 32'(pulses), 32'd1);
    check("step2.count", count, 32'd2);
    hold_btn(1'b0, 40, pulses, first_idx);

    // bounce: 5-cycle toggles never pass the debouncer
    tot = 0;
    for (int i = 0; i < 12; i++) begin
      hold_btn((i % 2) == 0, 5, pulses, first_idx);
      tot += pulses;
    end
    hold_btn(1'b0, 40, pulses, first_idx);
    tot += pulses;
    check("bounce.pulses", 32'(tot), 32'd0);
    check("bounce.count", count, 32'd2);

    // run for 100 cycles then stop, then clear
    sw = 8'h40; tick(); sw = 8'h00;
    check("preclear.count", count, 32'd0);
    sw = 8'h01;
    for (int i = 0; i < 100; i++) tick();
    sw = 8'h00;
    tick();
    check("run.count", count, 32'd100);
    check("run.state", 32'(state), 32'd0);
    check("run.cpu_en_off", 32'(cpu_en), 32'd0);
    sw = 8'h40; tick(); sw = 8'h00;
    check("clear.count", count, 32'd0);

    // halt on the 10th enabled cycle
    sw = 8'h01;
    tick();
    for (int i = 0; i < 9; i++) tick();
    op = 6'h3F;
    tick();
    op = 6'h00;
    check_outputs('{"halt", 2'd3, 1'b0, 1'b1, 32'd10});
    hold_btn(1'b1, 40, pulses, first_idx);
    check("halt.step_ignored", 32'(pulses), 32'd0);
    hold_btn(1'b0, 40, pulses, first_idx);
    check_outputs('{"halt_hold", 2'd3, 1'b0, 1'b1, 32'd10});
    sw = 8'h80;
    tick();
    sw = 8'h00;
    check_outputs('{"halt_clear", 2'd0, 1'b0, 1'b0, 32'd10});

    // wrap through 32'hFFFF_FFFF
    force dut.count_q = 32'hFFFF_FFFE;
    tick();
    sw = 8'h01;
    release dut.count_q;
    tick();
    check("wrap.preload", count, 32'hFFFF_FFFE);
    tick();
    tick();
    sw = 8'h00;
    tick();
    check("wrap.count", count, 32'd1);
    check("wrap.state", 32'(state), 32'd0);

    // reset aborts RUN
    sw = 8'h01;
    tick(); tick();
    rstd = 1'b1;
    tick();
    rstd = 1'b0; sw = 8'h00;
    check_outputs('{"reset_abort", 2'd0, 1'b0, 1'b0, 32'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
